// File: rtl/uart_tx_queue_if.sv
// Handshake bundle between a host, the UART transmit queue and its status.
// The host writes words and sees queue status; the queue drives the
// transmitter launch strobe and data word.
interface uart_tx_queue_if #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
);
    logic              wr;
    logic [DBIT-1:0]   wdata;
    logic              flush;
    logic              clr_ovf;
    logic              tx_done_tick;
    logic              tx_start;
    logic [DBIT-1:0]   tx_din;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;

    modport master (
        output wr, wdata, flush, clr_ovf, tx_done_tick,
        input  tx_start, tx_din, full, empty, count, overflow, busy
    );

    modport slave (
        input  wr, wdata, flush, clr_ovf, tx_done_tick,
        output tx_start, tx_din, full, empty, count, overflow, busy
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Circular word queue feeding a UART transmitter. Words are popped one at a
// time into a registered tx_din and launched with a one-cycle tx_start; the
// next word is only popped after the transmitter reports tx_done_tick.
module uart_tx_queue #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_queue_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t              state;
    logic [DBIT-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_nxt;
    logic                full_q;
    logic                empty_q;
    logic                ovf_q;
    logic                start_q;
    logic [DBIT-1:0]     din_q;
    logic                wr_acc;
    logic                wr_drop;
    logic                pop;

    // Flush clears the queue, so it also blocks any write or pop on that edge.
    assign wr_acc  = bus.wr && !full_q && !bus.flush;
    assign wr_drop = bus.wr &&  full_q && !bus.flush;
    assign pop     = (state == IDLE) && !empty_q && !bus.flush;

    // Next occupancy, from which the registered full/empty flags are derived.
    always_comb begin
        count_nxt = count_q;
        if (bus.flush) begin
            count_nxt = '0;
        end else begin
            unique case ({wr_acc, pop})
                2'b10:   count_nxt = count_q + 1'b1;
                2'b01:   count_nxt = count_q - 1'b1;
                default: count_nxt = count_q;
            endcase
        end
    end

    // Queue storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.wdata;
    end

    // Pointers, occupancy flags, overflow and the launch FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            din_q   <= '0;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == FULL_CNT);
            empty_q <= (count_nxt == '0);

            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end

            if (wr_drop)
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;

            start_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        din_q   <= mem[rd_ptr];
                        start_q <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (bus.tx_done_tick)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_start = start_q;
    assign bus.tx_din   = din_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state != IDLE) || !empty_q;
endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DBIT, default 8: width of queued data words and of tx_din.
REQ-002 Parameter ADDR_W, default 4: queue address width; depth is 2^ADDR_W entries (16 by default).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr  input  1  write strobe; a one-cycle pulse enqueues wdata.
REQ-006 wdata  input  DBIT  data word to enqueue.
REQ-007 flush  input  1  synchronous queue clear.
REQ-008 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 tx_done_tick  input  1  one-cycle completion pulse from the downstream transmitter.
REQ-010 tx_start  output  1  registered one-cycle launch pulse to the transmitter.
REQ-011 tx_din  output  DBIT  registered data word for the transmitter; held stable until the next pop.
REQ-012 full  output  1  high when count equals 2^ADDR_W.
REQ-013 empty  output  1  high when count equals 0.
REQ-014 count  output  ADDR_W+1  number of queued words, excluding the word in flight.
REQ-015 overflow  output  1  sticky flag indicating a write was dropped.
REQ-016 busy  output  1  high when the state is not IDLE or empty is low.

Function
REQ-017 The queue SHALL be circular storage with write and read pointers of ADDR_W bits; both pointers wrap from 2^ADDR_W-1 to 0.
REQ-018 A write SHALL be accepted at a clock edge when wr=1, full=0 and flush=0; wdata is stored at the write pointer, and the pointer increments.
REQ-019 When wr=1 and full=1, the write SHALL be dropped and overflow SHALL be set on that edge; storage, pointers and count are unchanged.
REQ-020 Overflow SHALL remain set until clr_ovf=1 or reset; if clr_ovf and a dropped write coincide, set takes priority.
REQ-021 The FSM SHALL have three states: IDLE, LAUNCH and WAIT.
REQ-022 In IDLE with empty=0, the next edge SHALL load tx_din from the read pointer, increment the read pointer and enter LAUNCH.
REQ-023 In LAUNCH, tx_start SHALL be 1 for exactly that one cycle; the next edge SHALL enter WAIT unconditionally.
REQ-024 In WAIT, tx_start SHALL be 0; tx_done_tick=1 SHALL return the FSM to IDLE. Otherwise the FSM stays in WAIT.
REQ-025 tx_done_tick SHALL be ignored in IDLE and LAUNCH.
REQ-026 Accepted write and pop on the same edge SHALL leave count unchanged; write only adds 1; pop only subtracts 1.
REQ-027 Latency: a word written into an empty queue while in IDLE at edge k SHALL produce tx_start=1 in the cycle after edge k+1.
REQ-028 Back-to-back words SHALL incur one IDLE cycle between tx_done_tick and the next pop, giving a minimum gap of 2 cycles from tx_done_tick to tx_start.
REQ-029 flush=1 SHALL zero both pointers and count, and SHALL override wr on that edge.
REQ-030 flush SHALL NOT alter the FSM state, tx_din or overflow; a frame in flight completes normally.
REQ-031 count, full and empty SHALL be registered and consistent with each other after every edge.

Reset
REQ-032 During reset, the block SHALL force: FSM=IDLE, pointers=0, count=0, full=0, empty=1, overflow=0, tx_start=0, tx_din=0, busy=0.
REQ-033 Reset asserted mid-frame SHALL abandon the word in flight and all queued words, with no tx_start after release until a new write occurs.
REQ-034 After reset release, the first edge SHALL accept writes normally.

Verification
REQ-035 Single word: write 0xA5 to an empty queue -> tx_start pulse of 1 cycle with tx_din=0xA5, two edges after the write; count returns to 0; busy=1 until tx_done_tick.
REQ-036 Order and gap: write 0x01, 0x02, 0x03 back-to-back, and return tx_done_tick 20 cycles after each tx_start -> three tx_start pulses carrying 0x01, 0x02, 0x03 in order, each no earlier than 2 cycles after the preceding tx_done_tick.
REQ-037 Fill and overflow: with tx_done_tick held 0, write 18 words (0x10..0x21) -> first word in flight, full=1 and count=16 after 17 writes; the 18th write is dropped and overflow=1; draining yields 0x10..0x20.
REQ-038 Simultaneous events: write while a pop occurs on the same edge -> count unchanged; clr_ovf with a dropped write on the same edge -> overflow stays 1.
REQ-039 Flush mid-frame: with 5 words queued and the FSM in WAIT, assert flush -> count=0 and empty=1; the in-flight word completes on tx_done_tick; no further tx_start.
REQ-040 Reset in WAIT with 3 words queued -> all outputs at their REQ-032 values asynchronously; no tx_start for 50 cycles after release.
